// File: rtl/bru_pkg.sv
// Shared types and field layout for the branch resolve unit.
// Packet, prediction and fetch-exception layouts live here so every stage agrees on them.
package bru_pkg;

    localparam int PC_W   = 32;
    localparam int TYPE_W = 2;
    localparam int INFO_W = 2 * PC_W + 1 + TYPE_W;

    localparam logic [TYPE_W-1:0] BR_NONE = 2'b00;
    localparam logic [TYPE_W-1:0] BR_COND = 2'b01;
    localparam logic [TYPE_W-1:0] BR_JUMP = 2'b10;
    localparam logic [TYPE_W-1:0] BR_JREG = 2'b11;

    localparam int BI_PC_HI   = 66;
    localparam int BI_PC_LO   = 35;
    localparam int BI_TAKEN   = 34;
    localparam int BI_TGT_HI  = 33;
    localparam int BI_TGT_LO  = 2;
    localparam int BI_TYPE_HI = 1;
    localparam int BI_TYPE_LO = 0;

    localparam int PP_DIR    = 32;
    localparam int PP_TGT_HI = 31;
    localparam int PP_TGT_LO = 0;

    localparam int FX_TLB_IINVALID = 0;
    localparam int FX_TLB_IILLEGAL = 1;
    localparam int FX_ADEL         = 2;
    localparam int FX_TLB_IMISS    = 3;
    localparam int FX_EXL          = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DS,
        REDIR
    } bru_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              taken;
        logic [PC_W-1:0]   target;
        logic [TYPE_W-1:0] btype;
    } br_info_t;

endpackage

// File: rtl/branch_mispredict_cmp.sv
// Compares a resolved branch with its fetch-time prediction.
// Produces the mispredict flag and the PC fetch must resume from.
module branch_mispredict_cmp
    import bru_pkg::*;
(
    input  logic [PC_W:0]   pred_pack,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_pc,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc
);

    logic            pred_dir;
    logic [PC_W-1:0] pred_target;

    assign pred_dir    = pred_pack[PP_DIR];
    assign pred_target = pred_pack[PP_TGT_HI:PP_TGT_LO];

    // wrong direction, or right direction but wrong taken target
    assign mispredict = (pred_dir != br_taken) |
                        (br_taken & (pred_target != br_target));

    // not-taken resumes after the delay slot; +8 wraps modulo 2^32
    assign correct_pc = br_taken ? br_target : br_pc + 32'd8;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: predictor training packet and delay-slot aware redirect.
// Optional macro BRU_PERF_CNT_EN adds branch / mispredict performance counters.
module branch_resolve_unit
    import bru_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_pc,
    input  logic [TYPE_W-1:0]  br_type,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [PC_W:0]      pred_pack,
    input  logic [4:0]         fetch_exc,
    input  logic               ds_valid,
    output logic [INFO_W-1:0]  branch_info_o,
    output logic               mispredict_o,
    output logic               redirect_o,
    output logic [PC_W-1:0]    redirect_pc_o,
    output logic               busy_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_br_cnt_o,
    output logic [31:0]        perf_miss_cnt_o
`endif
);

    bru_state_e      state_q;
    logic [PC_W-1:0] cap_pc_q;
    br_info_t        info_q;
    br_info_t        info_d;
    logic            exc_any;
    logic            qual;
    logic            miss;
    logic [PC_W-1:0] correct_pc;

    branch_mispredict_cmp u_cmp (
        .pred_pack  (pred_pack),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .br_pc      (br_pc),
        .mispredict (miss),
        .correct_pc (correct_pc)
    );

    assign exc_any = fetch_exc[FX_EXL]          |
                     fetch_exc[FX_TLB_IMISS]    |
                     fetch_exc[FX_ADEL]         |
                     fetch_exc[FX_TLB_IILLEGAL] |
                     fetch_exc[FX_TLB_IINVALID];

    // a branch seen while busy sits in a delay slot and is ignored
    assign qual = br_valid & ~stall & ~flush & ~exc_any &
                  (br_type != BR_NONE) & (state_q == IDLE);

    assign info_d = '{pc: br_pc, taken: br_taken,
                      target: br_target, btype: br_type};

    // training packet and mispredict pulse, zero on every non-qualified cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            info_q       <= '0;
            mispredict_o <= 1'b0;
        end else begin
            info_q       <= qual ? info_d : '0;
            mispredict_o <= qual & miss;
        end
    end

    // delay-slot sequencer: capture correct PC, wait for slot, redirect once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cap_pc_q <= '0;
        end else if (flush) begin
            state_q  <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (qual & miss) begin
                        cap_pc_q <= correct_pc;
                        state_q  <= ds_valid ? REDIR : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    if (ds_valid & ~stall) state_q <= REDIR;
                end
                REDIR: begin
                    if (~stall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // pulse must drop in the same cycle a stall or flush arrives
    assign redirect_o    = (state_q == REDIR) & ~stall & ~flush & ~rst;
    assign redirect_pc_o = redirect_o ? cap_pc_q : '0;
    assign busy_o        = (state_q != IDLE);
    assign branch_info_o = info_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    // free-running event counters; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (qual)        br_cnt_q   <= br_cnt_q + 32'd1;
            if (qual & miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_br_cnt_o   = br_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Build with +define+BRU_PERF_CNT_EN to also exercise the performance counters.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [1:0]  br_type;
    logic        br_taken;
    logic [31:0] br_target;
    logic [32:0] pred_pack;
    logic [4:0]  fetch_exc;
    logic        ds_valid;
    logic [66:0] branch_info_o;
    logic        mispredict_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_miss_cnt_o;
`endif

    int n_chk = 0;
    int n_err = 0;
    int redir_cnt = 0;
    int info_cnt = 0;
    bit mon_en = 1'b0;

    branch_resolve_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .br_valid      (br_valid),
        .br_pc         (br_pc),
        .br_type       (br_type),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .pred_pack     (pred_pack),
        .fetch_exc     (fetch_exc),
        .ds_valid      (ds_valid),
        .branch_info_o (branch_info_o),
        .mispredict_o  (mispredict_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .busy_o        (busy_o)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_br_cnt_o   (perf_br_cnt_o),
        .perf_miss_cnt_o (perf_miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (redirect_o) redir_cnt++;
            if (branch_info_o != '0) info_cnt++;
        end
        if (br_valid && busy_o)
            $display("note: protocol violation, br_valid while busy at %0t", $time);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [66:0] obs,
                       input logic [66:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [1:0] ty,
                            input logic tk, input logic [31:0] tgt,
                            input logic pdir, input logic [31:0] ptgt);
        br_valid  = 1'b1;
        br_pc     = pc;
        br_type   = ty;
        br_taken  = tk;
        br_target = tgt;
        pred_pack = {pdir, ptgt};
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_valid = 1'b0;
        br_pc = '0; br_type = '0; br_taken = 1'b0; br_target = '0;
        pred_pack = '0; fetch_exc = '0; ds_valid = 1'b0;
        tick();
        tick();
        chk("rst_info", branch_info_o, 67'd0);
        chk("rst_miss", {66'd0, mispredict_o}, 67'd0);
        chk("rst_redir", {66'd0, redirect_o}, 67'd0);
        chk("rst_rpc", {35'd0, redirect_pc_o}, 67'd0);
        chk("rst_busy", {66'd0, busy_o}, 67'd0);
`ifdef BRU_PERF_CNT_EN
        chk("rst_pbr", {35'd0, perf_br_cnt_o}, 67'd0);
        chk("rst_pmiss", {35'd0, perf_miss_cnt_o}, 67'd0);
`endif
        rst = 1'b0;
        tick();

        // correct prediction
        drive_br(32'h8000_1000, 2'b01, 1'b1, 32'h8000_1040, 1'b1, 32'h8000_1040);
        tick();
        br_valid = 1'b0;
        chk("ok_info", branch_info_o,
            {32'h8000_1000, 1'b1, 32'h8000_1040, 2'b01});
        chk("ok_miss", {66'd0, mispredict_o}, 67'd0);
        chk("ok_redir", {66'd0, redirect_o}, 67'd0);
        chk("ok_busy", {66'd0, busy_o}, 67'd0);
        tick();
        chk("ok_info0", branch_info_o, 67'd0);

        // direction miss, delay slot two cycles later
        drive_br(32'h8000_2000, 2'b01, 1'b0, 32'h8000_2100, 1'b1, 32'h8000_2100);
        tick();
        br_valid = 1'b0;
        chk("dir_info", branch_info_o,
            {32'h8000_2000, 1'b0, 32'h8000_2100, 2'b01});
        chk("dir_miss", {66'd0, mispredict_o}, 67'd1);
        chk("dir_busy", {66'd0, busy_o}, 67'd1);
        chk("dir_redir0", {66'd0, redirect_o}, 67'd0);
        tick();
        chk("dir_miss1", {66'd0, mispredict_o}, 67'd0);
        chk("dir_wait", {66'd0, busy_o}, 67'd1);
        ds_valid = 1'b1;
        tick();
        ds_valid = 1'b0;
        chk("dir_redir", {66'd0, redirect_o}, 67'd1);
        chk("dir_rpc", {35'd0, redirect_pc_o}, {35'd0, 32'h8000_2008});
        tick();
        chk("dir_redir_end", {66'd0, redirect_o}, 67'd0);
        chk("dir_idle", {66'd0, busy_o}, 67'd0);

        // register-jump target miss, delay slot with the branch
        drive_br(32'h8000_0300, 2'b11, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100);
        ds_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        ds_valid = 1'b0;
        chk("jr_miss", {66'd0, mispredict_o}, 67'd1);
        chk("jr_redir", {66'd0, redirect_o}, 67'd1);
        chk("jr_rpc", {35'd0, redirect_pc_o}, {35'd0, 32'h8000_0200});
        tick();
        chk("jr_redir_end", {66'd0, redirect_o}, 67'd0);
        chk("jr_idle", {66'd0, busy_o}, 67'd0);

        // stall across WAIT_DS and REDIR; not-taken PC wraps past 2^32
        redir_cnt = 0;
        info_cnt = 0;
        mon_en = 1'b1;
        drive_br(32'hFFFF_FFFC, 2'b01, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
        tick();
        br_valid = 1'b0;
        stall = 1'b1;
        ds_valid = 1'b1;
        #1;
        chk("st_miss", {66'd0, mispredict_o}, 67'd1);
        chk("st_redir0", {66'd0, redirect_o}, 67'd0);
        tick();
        stall = 1'b0;
        chk("st_hold_busy", {66'd0, busy_o}, 67'd1);
        chk("st_info0", branch_info_o, 67'd0);
        tick();
        ds_valid = 1'b0;
        stall = 1'b1;
        #1;
        chk("st_redir_stall1", {66'd0, redirect_o}, 67'd0);
        chk("st_busy_redir", {66'd0, busy_o}, 67'd1);
        tick();
        chk("st_redir_stall2", {66'd0, redirect_o}, 67'd0);
        tick();
        stall = 1'b0;
        #1;
        chk("st_redir", {66'd0, redirect_o}, 67'd1);
        chk("st_rpc_wrap", {35'd0, redirect_pc_o}, {35'd0, 32'h0000_0004});
        tick();
        chk("st_idle", {66'd0, busy_o}, 67'd0);
        mon_en = 1'b0;
        chk("st_one_pulse", {35'd0, 32'(redir_cnt)}, 67'd1);
        chk("st_one_info", {35'd0, 32'(info_cnt)}, 67'd1);

        // flush while waiting for the delay slot
        redir_cnt = 0;
        mon_en = 1'b1;
        drive_br(32'h8000_4000, 2'b01, 1'b1, 32'h8000_4080, 1'b0, 32'h0);
        tick();
        br_valid = 1'b0;
        flush = 1'b1;
        ds_valid = 1'b1;
        #1;
        chk("fl_busy", {66'd0, busy_o}, 67'd1);
        chk("fl_redir0", {66'd0, redirect_o}, 67'd0);
        tick();
        flush = 1'b0;
        chk("fl_idle", {66'd0, busy_o}, 67'd0);
        tick();
        ds_valid = 1'b0;
        chk("fl_noredir", {66'd0, redirect_o}, 67'd0);

        // fetch exception on a mispredicted branch
        drive_br(32'h8000_5000, 2'b01, 1'b1, 32'h8000_5040, 1'b0, 32'h0);
        fetch_exc = 5'b00010;
        ds_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        fetch_exc = '0;
        ds_valid = 1'b0;
        chk("fx_info", branch_info_o, 67'd0);
        chk("fx_miss", {66'd0, mispredict_o}, 67'd0);
        chk("fx_busy", {66'd0, busy_o}, 67'd0);
        tick();
        mon_en = 1'b0;
        chk("fx_noredir", {35'd0, 32'(redir_cnt)}, 67'd0);

        // branch in the delay slot is ignored
        drive_br(32'h8000_6000, 2'b10, 1'b1, 32'h8000_6100, 1'b0, 32'h0);
        tick();
        drive_br(32'h8000_6004, 2'b01, 1'b1, 32'h8000_6200, 1'b1, 32'h8000_6200);
        tick();
        br_valid = 1'b0;
        chk("ds_br_info", branch_info_o, 67'd0);
        chk("ds_br_miss", {66'd0, mispredict_o}, 67'd0);
        ds_valid = 1'b1;
        tick();
        ds_valid = 1'b0;
        chk("ds_br_rpc", {35'd0, redirect_pc_o}, {35'd0, 32'h8000_6100});
        tick();

        // type none never trains
        drive_br(32'h8000_7000, 2'b00, 1'b1, 32'h8000_7040, 1'b0, 32'h0);
        tick();
        br_valid = 1'b0;
        chk("none_info", branch_info_o, 67'd0);
        chk("none_busy", {66'd0, busy_o}, 67'd0);

        // reset in the middle of a sequence
        drive_br(32'h8000_8000, 2'b01, 1'b0, 32'h8000_8100, 1'b1, 32'h8000_8100);
        tick();
        br_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ds_valid = 1'b1;
        chk("mr_busy", {66'd0, busy_o}, 67'd0);
        chk("mr_info", branch_info_o, 67'd0);
        tick();
        ds_valid = 1'b0;
        chk("mr_noredir", {66'd0, redirect_o}, 67'd0);

`ifdef BRU_PERF_CNT_EN
        // miss counter wraps from all-ones
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt_q;
        drive_br(32'h8000_9000, 2'b01, 1'b1, 32'h8000_9010, 1'b1, 32'h8000_9020);
        ds_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        ds_valid = 1'b0;
        chk("pc_miss_wrap", {35'd0, perf_miss_cnt_o}, 67'd0);
        chk("pc_br_inc", {35'd0, perf_br_cnt_o}, 67'd1);
        chk("pc_rpc", {35'd0, redirect_pc_o}, {35'd0, 32'h8000_9010});
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits in EX, between the branch comparator/ALU and the fetch-stage branch predictor.
- Compares each resolved branch against the prediction that travelled with it, and emits the 67-bit training packet the predictor consumes.
- On a misprediction, sequences the MIPS delay-slot rule: waits for the delay slot to issue, then redirects fetch to the correct PC.

Parameters:
- PC_W, 32, address width.
- TYPE_W, 2, branch type width. Codes: 00 none, 01 conditional, 10 direct jump, 11 register jump.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  EX stall; freezes the block
- flush  in  1  exception/ERET flush from CP0; kills pending redirect
- br_valid  in  1  a branch/jump is resolving in EX this cycle
- br_pc  in  32  PC of the branch
- br_type  in  2  branch type code
- br_taken  in  1  actual direction
- br_target  in  32  actual target (computed even when not taken)
- pred_pack  in  33  {pred_dir, pred_target} carried down from fetch
- fetch_exc  in  5  {exl, tlb_imiss, adel, tlb_iillegal, tlb_iinvalid} carried from fetch
- ds_valid  in  1  delay-slot instruction accepted into EX this cycle
- branch_info_o  out  67  {pc[66:35], taken[34], target[33:2], type[1:0]}; all-zero means no update
- mispredict_o  out  1  one-cycle pulse on detection; ID squashes wrong-path instructions behind the delay slot
- redirect_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  32  correct PC, valid while redirect_o=1
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, captured PC 0.
- Qualified branch: br_valid & !stall & !flush & (fetch_exc==0) & (br_type!=0) & FSM==IDLE.
  - Unqualified cycles produce no update and no detection.
- Mispredict: pred_dir != br_taken, OR (br_taken & pred_target != br_target).
- Correct PC: br_taken ? br_target : br_pc + 8. The +8 skips the delay slot and wraps modulo 2^32.
- branch_info_o is registered, 1-cycle latency after the qualified cycle.
  - It carries {br_pc, br_taken, br_target, br_type} for every qualified branch, whether predicted correctly or not.
  - It is zero in every other cycle, including stall cycles, so a stalled branch is never trained twice.
  - br_type != 0 guarantees bits [34:0] are nonzero for a valid packet.
- mispredict_o is registered, aligned with the branch_info_o cycle, and asserted only for a qualified mispredict.
- FSM:
  - IDLE: on a qualified mispredict, capture the correct PC and go to WAIT_DS.
    - If ds_valid is also 1 in that cycle (delay slot issued with the branch), go directly to REDIR.
  - WAIT_DS: hold. On ds_valid & !stall, go to REDIR.
  - REDIR: redirect_o=1 and redirect_pc_o=captured PC for exactly one cycle, then go to IDLE.
- stall=1 in any state: FSM holds and redirect_o is held at 0. The REDIR pulse fires on the first non-stalled REDIR cycle.
- flush=1 in any state: next state IDLE, no redirect. Flush overrides a simultaneous mispredict or ds_valid.
- br_valid while busy (a branch in the delay slot, architecturally undefined) is ignored: no packet, no detection. The bench flags it as a protocol violation.
- A fetch exception on a branch suppresses both training and redirect; the exception flush recovers.
- rst mid-sequence: returns to IDLE at the next edge, and no redirect is emitted.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined: adds outputs perf_br_cnt_o[31:0] and perf_miss_cnt_o[31:0].
  - perf_br_cnt_o increments on each qualified branch; perf_miss_cnt_o increments on each qualified mispredict.
  - Both wrap at 2^32 and are cleared by rst. They are not cleared by flush.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package bru_pkg holds:
  - branch type codes;
  - branch_info field ranges (PC 66:35, TAKEN 34, TARGET 33:2, TYPE 1:0);
  - pred_pack ranges (DIR 32, TARGET 31:0);
  - the fetch_exc bit positions;
  - the FSM state enum (IDLE, WAIT_DS, REDIR).
- One combinational sub-module, branch_mispredict_cmp: takes pred_pack, br_taken, br_target and br_pc; outputs the mispredict flag and the correct PC.

Test Plan:
- Correct prediction: br_pc=0x80001000, conditional, taken, target 0x80001040, pred_pack={1,0x80001040}.
  - Next cycle branch_info_o = {0x80001000, 1, 0x80001040, 2'b01}.
  - mispredict_o=0, no redirect.
- Direction miss: pred_dir=1, actual not taken, br_pc=0x80002000. ds_valid asserted 2 cycles later.
  - mispredict_o pulses.
  - redirect_o=1 with redirect_pc_o=0x80002008, one cycle after ds_valid.
- Target miss on register jump: pred {1,0x80000100}, actual target 0x80000200, ds_valid in the same cycle.
  - Go straight to REDIR; redirect to 0x80000200 on the following cycle.
- Stall mid-sequence: stall=1 for 3 cycles during WAIT_DS and REDIR.
  - FSM holds; exactly one redirect pulse after stall drops.
  - branch_info_o is nonzero for exactly one cycle.
- Flush in WAIT_DS, and a mispredict with fetch_exc=5'b00010:
  - no redirect;
  - no packet for the faulting branch;
  - busy_o returns to 0.
- BRU_PERF_CNT_EN defined, with perf_miss_cnt_o preloaded to 0xFFFFFFFF via force: one mispredict wraps it to 0, and perf_br_cnt_o increments by 1.
